// File: rtl/up_axi_master.sv
// up_axi_master: bridges the pulse-request up register bus onto an AXI4-Lite
// master port. The write and read engines are independent, each with one
// outstanding transaction, a saturating timeout and an error flag on the ack.
module up_axi_master #(
    parameter logic [31:0] ADDR_BASE = 32'h00000000,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic        up_clk,
    input  logic        up_rstn,

    input  logic        up_wreq,
    input  logic [13:0] up_waddr,
    input  logic [31:0] up_wdata,
    output logic        up_wack,
    output logic        up_werr,
    output logic        up_wbusy,

    input  logic        up_rreq,
    input  logic [13:0] up_raddr,
    output logic [31:0] up_rdata,
    output logic        up_rack,
    output logic        up_rerr,
    output logic        up_rbusy,

    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic [1:0]  m_axi_bresp,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp
);

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_DRAIN} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DRAIN} rstate_t;

    wstate_t     w_state, w_state_nxt;
    rstate_t     r_state, r_state_nxt;

    logic        awvalid_nxt, wvalid_nxt, bready_nxt, wack_nxt, werr_nxt;
    logic [31:0] awaddr_nxt, wdata_nxt;
    logic [15:0] w_tmr, w_tmr_nxt, w_tmr_inc;
    logic        w_tmo;

    logic        arvalid_nxt, rready_nxt, rack_nxt, rerr_nxt;
    logic [31:0] araddr_nxt, rdata_nxt;
    logic [15:0] r_tmr, r_tmr_nxt, r_tmr_inc;
    logic        r_tmo;

    assign m_axi_wstrb  = 4'hf;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    assign up_wbusy = (w_state != W_IDLE);
    assign up_rbusy = (r_state != R_IDLE);

    // Timeout fires on the edge where the timer reaches TIMEOUT, so the abort
    // ack lands TIMEOUT+1 cycles after the request cycle.
    assign w_tmr_inc = (w_tmr == '1) ? w_tmr : w_tmr + 16'd1;
    assign r_tmr_inc = (r_tmr == '1) ? r_tmr : r_tmr + 16'd1;
    assign w_tmo     = (TIMEOUT != 0) && ({16'd0, w_tmr_inc} >= TIMEOUT);
    assign r_tmo     = (TIMEOUT != 0) && ({16'd0, r_tmr_inc} >= TIMEOUT);

    // Write engine: next state and next values of all registered outputs.
    always_comb begin
        w_state_nxt = w_state;
        awvalid_nxt = m_axi_awvalid & ~m_axi_awready;
        wvalid_nxt  = m_axi_wvalid & ~m_axi_wready;
        bready_nxt  = m_axi_bready;
        awaddr_nxt  = m_axi_awaddr;
        wdata_nxt   = m_axi_wdata;
        wack_nxt    = 1'b0;
        werr_nxt    = 1'b0;
        w_tmr_nxt   = w_tmr;
        unique case (w_state)
            W_IDLE: begin
                if (up_wreq) begin
                    awaddr_nxt  = ADDR_BASE | {16'd0, up_waddr, 2'b00};
                    wdata_nxt   = up_wdata;
                    awvalid_nxt = 1'b1;
                    wvalid_nxt  = 1'b1;
                    w_tmr_nxt   = '0;
                    w_state_nxt = W_REQ;
                end
            end
            W_REQ: begin
                w_tmr_nxt = w_tmr_inc;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    bready_nxt  = 1'b1;
                    w_state_nxt = W_RESP;
                end else if (w_tmo) begin
                    wack_nxt    = 1'b1;
                    werr_nxt    = 1'b1;
                    bready_nxt  = 1'b1;
                    w_state_nxt = W_DRAIN;
                end
            end
            W_RESP: begin
                w_tmr_nxt = w_tmr_inc;
                if (m_axi_bvalid) begin
                    bready_nxt  = 1'b0;
                    wack_nxt    = 1'b1;
                    werr_nxt    = |m_axi_bresp;
                    w_state_nxt = W_IDLE;
                end else if (w_tmo) begin
                    wack_nxt    = 1'b1;
                    werr_nxt    = 1'b1;
                    w_state_nxt = W_DRAIN;
                end
            end
            W_DRAIN: begin
                // bready low here means the B beat was already taken.
                if (m_axi_bvalid && m_axi_bready) bready_nxt = 1'b0;
                if ((!m_axi_bready || m_axi_bvalid) && !awvalid_nxt && !wvalid_nxt)
                    w_state_nxt = W_IDLE;
            end
        endcase
    end

    // Write engine state and output registers.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            w_state       <= W_IDLE;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            up_wack       <= 1'b0;
            up_werr       <= 1'b0;
            w_tmr         <= '0;
        end else begin
            w_state       <= w_state_nxt;
            m_axi_awvalid <= awvalid_nxt;
            m_axi_wvalid  <= wvalid_nxt;
            m_axi_bready  <= bready_nxt;
            m_axi_awaddr  <= awaddr_nxt;
            m_axi_wdata   <= wdata_nxt;
            up_wack       <= wack_nxt;
            up_werr       <= werr_nxt;
            w_tmr         <= w_tmr_nxt;
        end
    end

    // Read engine: next state and next values of all registered outputs.
    always_comb begin
        r_state_nxt = r_state;
        arvalid_nxt = m_axi_arvalid & ~m_axi_arready;
        rready_nxt  = m_axi_rready;
        araddr_nxt  = m_axi_araddr;
        rdata_nxt   = up_rdata;
        rack_nxt    = 1'b0;
        rerr_nxt    = 1'b0;
        r_tmr_nxt   = r_tmr;
        unique case (r_state)
            R_IDLE: begin
                if (up_rreq) begin
                    araddr_nxt  = ADDR_BASE | {16'd0, up_raddr, 2'b00};
                    arvalid_nxt = 1'b1;
                    r_tmr_nxt   = '0;
                    r_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                r_tmr_nxt = r_tmr_inc;
                if (m_axi_arready) begin
                    rready_nxt  = 1'b1;
                    r_state_nxt = R_DATA;
                end else if (r_tmo) begin
                    rack_nxt    = 1'b1;
                    rerr_nxt    = 1'b1;
                    rdata_nxt   = 32'hdead_dead;
                    rready_nxt  = 1'b1;
                    r_state_nxt = R_DRAIN;
                end
            end
            R_DATA: begin
                r_tmr_nxt = r_tmr_inc;
                if (m_axi_rvalid) begin
                    rready_nxt  = 1'b0;
                    rack_nxt    = 1'b1;
                    rerr_nxt    = |m_axi_rresp;
                    rdata_nxt   = m_axi_rdata;
                    r_state_nxt = R_IDLE;
                end else if (r_tmo) begin
                    rack_nxt    = 1'b1;
                    rerr_nxt    = 1'b1;
                    rdata_nxt   = 32'hdead_dead;
                    r_state_nxt = R_DRAIN;
                end
            end
            R_DRAIN: begin
                if (m_axi_rvalid && m_axi_rready) rready_nxt = 1'b0;
                if ((!m_axi_rready || m_axi_rvalid) && !arvalid_nxt)
                    r_state_nxt = R_IDLE;
            end
        endcase
    end

    // Read engine state and output registers.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            r_state       <= R_IDLE;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_araddr  <= '0;
            up_rdata      <= '0;
            up_rack       <= 1'b0;
            up_rerr       <= 1'b0;
            r_tmr         <= '0;
        end else begin
            r_state       <= r_state_nxt;
            m_axi_arvalid <= arvalid_nxt;
            m_axi_rready  <= rready_nxt;
            m_axi_araddr  <= araddr_nxt;
            up_rdata      <= rdata_nxt;
            up_rack       <= rack_nxt;
            up_rerr       <= rerr_nxt;
            r_tmr         <= r_tmr_nxt;
        end
    end

endmodule

// File: tb/tb_up_axi_master.sv
// tb_up_axi_master: randomized and directed stimulus for up_axi_master against
// a delay-programmable AXI4-Lite slave; expected latencies, addresses, data
// and error flags are computed from the bus rules, not from the RTL.
module tb_up_axi_master;

    localparam logic [31:0] BASE = 32'h4300_0000;
    localparam int unsigned TO   = 16;

    logic        up_clk = 1'b0;
    logic        up_rstn;
    logic        up_wreq, up_rreq;
    logic [13:0] up_waddr, up_raddr;
    logic [31:0] up_wdata;
    logic        up_wack, up_werr, up_wbusy;
    logic [31:0] up_rdata;
    logic        up_rack, up_rerr, up_rbusy;

    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;

    up_axi_master #(.ADDR_BASE(BASE), .TIMEOUT(TO)) dut (
        .up_clk(up_clk), .up_rstn(up_rstn),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata),
        .up_wack(up_wack), .up_werr(up_werr), .up_wbusy(up_wbusy),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata),
        .up_rack(up_rack), .up_rerr(up_rerr), .up_rbusy(up_rbusy),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
    );

    always #5 up_clk = ~up_clk;

    int unsigned cyc = 0;
    int unsigned n_chk = 0, n_err = 0;

    // slave configuration (written by the transaction tasks)
    int unsigned aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int unsigned r_hold_cyc = 0;
    bit          b_hold = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;

    // slave bookkeeping and captures
    bit          got_aw, got_w, got_ar, aw_fire, w_fire, b_fire, ar_fire, r_fire;
    bit          pv_aw, pv_w, pv_ar;
    int unsigned aw_w, w_w, b_w, ar_w, r_w;
    int unsigned aw_hs = 0, w_hs = 0, ar_hs = 0, viol = 0;
    int unsigned wack_cnt = 0, rack_cnt = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;
    logic [2:0]  cap_awprot = '0, cap_arprot = '0;

    always @(posedge up_clk) cyc++;

    // count up-side completions
    always @(negedge up_clk) begin
        if (up_wack) wack_cnt++;
        if (up_rack) rack_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // AXI4-Lite slave: decides readies/responses mid-cycle for the coming edge
    always @(negedge up_clk) begin
        if (!up_rstn) begin
            m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
            m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
            m_axi_bresp = 2'b00; m_axi_rresp = 2'b00; m_axi_rdata = '0;
            got_aw = 0; got_w = 0; got_ar = 0;
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
            pv_aw = 0; pv_w = 0; pv_ar = 0;
            aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
        end else begin
            if (pv_aw && !aw_fire && !m_axi_awvalid) viol++;
            if (pv_w  && !w_fire  && !m_axi_wvalid)  viol++;
            if (pv_ar && !ar_fire && !m_axi_arvalid) viol++;
            if (aw_fire) got_aw = 1;
            if (w_fire)  got_w  = 1;
            if (ar_fire) got_ar = 1;
            if (b_fire) begin m_axi_bvalid = 0; got_aw = 0; got_w = 0; b_w = 0; end
            if (r_fire) begin m_axi_rvalid = 0; got_ar = 0; r_w = 0; end

            if (m_axi_awvalid && !got_aw) begin m_axi_awready = (aw_w >= aw_dly); aw_w++; end
            else begin m_axi_awready = 0; aw_w = 0; end
            if (m_axi_wvalid && !got_w) begin m_axi_wready = (w_w >= w_dly); w_w++; end
            else begin m_axi_wready = 0; w_w = 0; end
            if (m_axi_arvalid && !got_ar) begin m_axi_arready = (ar_w >= ar_dly); ar_w++; end
            else begin m_axi_arready = 0; ar_w = 0; end

            if (got_aw && got_w && !m_axi_bvalid && !b_hold) begin
                if (b_w >= b_dly) begin m_axi_bvalid = 1; m_axi_bresp = bresp_cfg; end
                b_w++;
            end
            if (got_ar && !m_axi_rvalid && cyc >= r_hold_cyc) begin
                if (r_w >= r_dly) begin
                    m_axi_rvalid = 1; m_axi_rresp = rresp_cfg; m_axi_rdata = rdata_cfg;
                end
                r_w++;
            end

            aw_fire = m_axi_awvalid && m_axi_awready;
            w_fire  = m_axi_wvalid && m_axi_wready;
            ar_fire = m_axi_arvalid && m_axi_arready;
            b_fire  = m_axi_bvalid && m_axi_bready;
            r_fire  = m_axi_rvalid && m_axi_rready;
            if (aw_fire) begin aw_hs++; cap_awaddr = m_axi_awaddr; cap_awprot = m_axi_awprot; end
            if (w_fire)  begin w_hs++; cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; end
            if (ar_fire) begin ar_hs++; cap_araddr = m_axi_araddr; cap_arprot = m_axi_arprot; end
            pv_aw = m_axi_awvalid; pv_w = m_axi_wvalid; pv_ar = m_axi_arvalid;
        end
    end

    // One write; expected ack latency = 1 (valids) + slower ready delay
    // + 1 (B one cycle after) + B delay + 1 (registered ack). extra>0 pulses
    // a second request that many cycles after the first; it must be ignored.
    task automatic do_write(input logic [13:0] a, input logic [31:0] d,
                            input int unsigned da, input int unsigned dw,
                            input int unsigned db, input logic [1:0] resp,
                            input int unsigned extra);
        int unsigned n, exp_lat, got_lat, aw0, w0, ack0;
        bit seen;
        aw_dly = da; w_dly = dw; b_dly = db; bresp_cfg = resp;
        aw0 = aw_hs; w0 = w_hs; ack0 = wack_cnt;
        exp_lat = 3 + ((da > dw) ? da : dw) + db;
        seen = 0; got_lat = 0;
        @(negedge up_clk);
        up_wreq = 1'b1; up_waddr = a; up_wdata = d; n = cyc;
        for (int unsigned k = 1; k <= 48 && !seen; k++) begin
            @(negedge up_clk);
            up_wreq = (k == extra);
            if (k == extra) begin up_waddr = ~a; up_wdata = ~d; end
            if (up_wack) begin
                seen = 1; got_lat = cyc - n;
                chk("wr_err", {31'd0, up_werr}, {31'd0, resp != 2'b00});
            end
        end
        chk("wr_ack_seen", {31'd0, seen}, 32'd1);
        chk("wr_latency", got_lat, exp_lat);
        repeat (3) @(negedge up_clk);
        #1;
        chk("wr_ack_count", wack_cnt - ack0, 32'd1);
        chk("wr_aw_count", aw_hs - aw0, 32'd1);
        chk("wr_w_count", w_hs - w0, 32'd1);
        chk("wr_awaddr", cap_awaddr, BASE | (32'(a) << 2));
        chk("wr_wdata", cap_wdata, d);
        chk("wr_wstrb", {28'd0, cap_wstrb}, 32'hf);
        chk("wr_awprot", {29'd0, cap_awprot}, 32'd0);
        chk("wr_idle", {31'd0, up_wbusy}, 32'd0);
    endtask

    // One read; rvalid is additionally withheld until request cycle + hold.
    // If the natural completion comes later than TIMEOUT+1 cycles the
    // abort ack is expected instead, followed by a drain until rvalid.
    task automatic do_read(input logic [13:0] a, input int unsigned da,
                           input int unsigned dr, input logic [1:0] resp,
                           input logic [31:0] d, input int unsigned hold);
        int unsigned n, exp_lat, got_lat, ar0, ack0;
        logic [31:0] exp_data;
        bit seen, tmo;
        ar_dly = da; r_dly = dr; rresp_cfg = resp; rdata_cfg = d;
        ar0 = ar_hs; ack0 = rack_cnt;
        exp_lat = 3 + da + dr;
        if (hold + 1 > exp_lat) exp_lat = hold + 1;
        tmo = (exp_lat > TO + 1);
        if (tmo) exp_lat = TO + 1;
        exp_data = tmo ? 32'hdead_dead : d;
        seen = 0; got_lat = 0;
        @(negedge up_clk);
        up_rreq = 1'b1; up_raddr = a; n = cyc; r_hold_cyc = cyc + hold;
        for (int unsigned k = 1; k <= 64 && !seen; k++) begin
            @(negedge up_clk);
            up_rreq = 1'b0;
            if (up_rack) begin
                seen = 1; got_lat = cyc - n;
                chk("rd_err", {31'd0, up_rerr}, {31'd0, tmo || resp != 2'b00});
                chk("rd_data", up_rdata, exp_data);
            end
        end
        chk("rd_ack_seen", {31'd0, seen}, 32'd1);
        chk("rd_latency", got_lat, exp_lat);
        if (tmo) begin
            while (cyc < n + 30) @(negedge up_clk);
            chk("rd_drain_rready", {31'd0, m_axi_rready}, 32'd1);
            chk("rd_drain_busy", {31'd0, up_rbusy}, 32'd1);
            seen = 0;
            for (int unsigned k = 0; k < 64 && !seen; k++) begin
                @(negedge up_clk);
                if (!up_rbusy) begin seen = 1; got_lat = cyc - n; end
            end
            chk("rd_drain_done", {31'd0, seen}, 32'd1);
            chk("rd_drain_latency", got_lat, hold + 1);
        end
        repeat (3) @(negedge up_clk);
        #1;
        chk("rd_data_hold", up_rdata, exp_data);
        chk("rd_ack_count", rack_cnt - ack0, 32'd1);
        chk("rd_ar_count", ar_hs - ar0, 32'd1);
        chk("rd_araddr", cap_araddr, BASE | (32'(a) << 2));
        chk("rd_arprot", {29'd0, cap_arprot}, 32'd0);
        r_hold_cyc = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {21'd0, up_wack, up_werr, up_wbusy, up_rack, up_rerr, up_rbusy,
                             m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                             m_axi_rready}, 32'd0);
        chk({tag, "_rdata"}, up_rdata, 32'd0);
        chk({tag, "_awaddr"}, m_axi_awaddr, 32'd0);
        chk({tag, "_wdata"}, m_axi_wdata, 32'd0);
        chk({tag, "_araddr"}, m_axi_araddr, 32'd0);
        chk({tag, "_wstrb"}, {28'd0, m_axi_wstrb}, 32'hf);
        chk({tag, "_prot"}, {26'd0, m_axi_awprot, m_axi_arprot}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n, ack0, mode;
        logic [31:0] rd;
        up_rstn = 1'b0; up_wreq = 1'b0; up_rreq = 1'b0;
        up_waddr = '0; up_raddr = '0; up_wdata = '0;
        repeat (3) @(negedge up_clk);
        #1;
        chk_reset_outputs("reset");
        up_rstn = 1'b1;
        repeat (2) @(negedge up_clk);

        // zero-wait write
        do_write(14'h0010, 32'h1234_5678, 0, 0, 0, 2'b00, 0);

        // wready long before awready, SLVERR response
        fork
            do_write(14'h0021, 32'ha5a5_0f0f, 5, 0, 0, 2'b10, 0);
            begin
                repeat (3) @(negedge up_clk);
                chk("wfirst_wvalid", {31'd0, m_axi_wvalid}, 32'd0);
                chk("wfirst_awvalid", {31'd0, m_axi_awvalid}, 32'd1);
            end
        join

        // read with 3-cycle arready delay
        do_read(14'h0002, 3, 0, 2'b00, 32'hcafe_0001, 0);

        // simultaneous write and read, plus a write request while busy
        fork
            do_write(14'h0123, 32'h0bad_f00d, 0, 0, 0, 2'b00, 1);
            do_read(14'h3fff, 0, 0, 2'b00, 32'h5555_aaaa, 0);
        join

        // read timeout, slave holds rvalid off until request + 40
        do_read(14'h0abc, 0, 0, 2'b00, 32'h7777_1111, 40);

        // asynchronous reset while the write engine waits for its response
        b_hold = 1'b1;
        ack0 = wack_cnt;
        @(negedge up_clk);
        up_wreq = 1'b1; up_waddr = 14'h0042; up_wdata = 32'h0102_0304; n = cyc;
        @(negedge up_clk);
        up_wreq = 1'b0;
        while (cyc < n + 4) @(negedge up_clk);
        chk("rst_in_resp", {30'd0, up_wbusy, m_axi_bready}, 32'd3);
        #1 up_rstn = 1'b0;
        #1 chk_reset_outputs("rst_async");
        repeat (2) @(negedge up_clk);
        #1 up_rstn = 1'b1;
        b_hold = 1'b0;
        repeat (3) @(negedge up_clk);
        #1 chk("rst_no_ack", wack_cnt - ack0, 32'd0);
        do_write(14'h0043, 32'h0506_0708, 0, 0, 0, 2'b00, 0);

        // randomized traffic, all within the timeout window
        for (int i = 0; i < 24; i++) begin
            mode = $urandom_range(0, 2);
            rd = $urandom;
            if (mode == 0) begin
                do_write(14'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                         $urandom_range(0, 4), 2'($urandom), 0);
            end else if (mode == 1) begin
                do_read(14'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                        2'($urandom), rd, 0);
            end else begin
                fork
                    do_write(14'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                             $urandom_range(0, 4), 2'($urandom), $urandom_range(0, 2));
                    do_read(14'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                            2'($urandom), rd, 0);
                join
            end
        end

        chk("axi_valid_stable", viol, 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/up_axi_master.md
Name: up_axi_master

Overview:
- Initiator-side bridge. Converts the simple internal up register bus (pulse request / pulse ack) into AXI4-Lite master transactions.
- Lets a local sequencer or calibration engine program any AXI-lite peripheral (e.g. another axi_ad96xx core) through its up_axi slave.
- Independent write and read engines, one outstanding transaction each, with per-transaction timeout and error reporting.

Parameters:
- ADDR_BASE, 32'h00000000, byte base OR'ed into every AXI address.
- TIMEOUT, 1023, up_clk cycles from request acceptance to up-side abort (0 disables the timeout).

Ports:
- up_clk  in  1  clock for all logic
- up_rstn  in  1  asynchronous active-low reset
- up_wreq  in  1  single-cycle write request
- up_waddr  in  14  word address
- up_wdata  in  32  write data
- up_wack  out  1  single-cycle write completion
- up_werr  out  1  valid with up_wack; 1 = SLVERR/DECERR or timeout
- up_wbusy  out  1  write engine not idle
- up_rreq  in  1  single-cycle read request
- up_raddr  in  14  word address
- up_rdata  out  32  read data, valid with up_rack
- up_rack  out  1  single-cycle read completion
- up_rerr  out  1  valid with up_rack
- up_rbusy  out  1  read engine not idle
- m_axi_awvalid/awready/awaddr[32]/awprot[3], m_axi_wvalid/wready/wdata[32]/wstrb[4], m_axi_bvalid/bready/bresp[2], m_axi_arvalid/arready/araddr[32]/arprot[3], m_axi_rvalid/rready/rdata[32]/rresp[2]: standard AXI4-Lite master signals.

Behaviour:
- Reset: every output is 0, except m_axi_wstrb = 4'hf and the prot outputs = 3'b000 (both constant). Both FSMs go to IDLE. Reset mid-transaction abandons it with no ack.
- Address mapping: axaddr = ADDR_BASE | {16'd0, addr, 2'b00}. Address and data are registered at acceptance.

Write FSM:
- W_IDLE
  - If up_wreq: latch the request, raise awvalid and wvalid next cycle, start the timer, go to W_REQ.
- W_REQ
  - awvalid drops on the cycle after awready&awvalid; wvalid drops independently on its own handshake.
  - Once both handshakes are done (either order, or same cycle): bready = 1, go to W_RESP.
- W_RESP
  - On bvalid&bready: bready = 0; one cycle later up_wack = 1 and up_werr = |bresp; go to W_IDLE.
- Timeout: when the timer reaches TIMEOUT in W_REQ or W_RESP, up_wack = 1 and up_werr = 1, go to W_DRAIN.
- W_DRAIN
  - Keeps any still-asserted valid until its handshake, keeps bready = 1 until bvalid, then goes to W_IDLE with no further ack.
  - Never emits a second ack for the aborted transaction.

Read FSM:
- Sequence R_IDLE -> R_ADDR -> R_DATA.
- R_ADDR: arvalid held until arready.
- R_DATA: rready = 1. On rvalid&rready, next cycle up_rack = 1, up_rdata = rdata, up_rerr = |rresp.
- Timeout: up_rack = 1, up_rdata = 32'hdead_dead, up_rerr = 1, go to R_DRAIN (same rules as W_DRAIN).
- up_rdata holds its value until the next rack. It is 0 after reset.

Common rules:
- Latency with a zero-wait slave (ready high, response the cycle after the handshake):
  - write: req at cycle N, valids at N+1, bvalid at N+2, up_wack at N+3;
  - read: same, up_rack at N+3.
- AXI rules: a valid never drops before its ready. Valids do not depend on readies combinationally. bready/rready are registered.
- up_wbusy/up_rbusy = state != IDLE. A req arriving while busy is silently dropped (requester must wait for !busy).
- Write and read engines run concurrently. Simultaneous up_wreq and up_rreq are both accepted.
- Timer: 16-bit, cleared on acceptance, saturating, compared with >= TIMEOUT. It runs only in REQ/RESP/ADDR/DATA.

Test Plan:
- Zero-wait slave: write addr 14'h0010, data 32'h1234_5678 -> awaddr = ADDR_BASE|32'h40, wdata = 32'h12345678, wstrb = f; up_wack at req+3, up_werr = 0.
- wready 5 cycles before awready; then bresp = 2'b10 -> wvalid drops first, awvalid held until its handshake; up_wack with up_werr = 1.
- Read of 14'h0002 returning 32'hcafe_0001 with 3-cycle arready delay and rresp = 0 -> araddr = 32'h8; up_rack at req+6, up_rdata = 32'hcafe0001.
- Simultaneous up_wreq and up_rreq, plus an extra up_wreq while busy -> both complete; the extra write produces no AXI traffic and no ack.
- TIMEOUT = 16, slave never asserts rvalid until cycle 40 -> up_rack at req+17 with rdata dead_dead and rerr = 1; rready is held until rvalid at cycle 40; rbusy stays high until then; exactly one rack.
- Assert up_rstn low during W_RESP -> all outputs 0 asynchronously; after release, a new write completes normally.
